// File: rtl/dec_ej_1.sv
// Countdown engine: loads a value and subtracts an operand-selected step on each
// enabled cycle, reporting completion, underflow and the enabled-cycle count.
module dec_ej_1 #(
    parameter int unsigned NB_DATA = 3,
    parameter int unsigned NB_ACC  = 6,
    parameter int unsigned NB_CNT  = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_load_valid,
    output logic               o_load_ready,
    input  logic [NB_ACC-1:0]  i_load_value,
    input  logic [NB_DATA-1:0] i_data1,
    input  logic [NB_DATA-1:0] i_data2,
    input  logic [1:0]         i_sel,
    input  logic               i_enable,
    output logic [NB_ACC-1:0]  o_data,
    output logic               o_underflow,
    output logic               o_done,
    output logic               o_busy,
    output logic [NB_CNT-1:0]  o_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;

    logic [NB_DATA:0]  step_c;
    logic [NB_ACC-1:0] step_ext_c;
    logic [NB_ACC-1:0] diff_c;

    // Step select mirrors the adder side's i_sel encoding
    always_comb begin
        step_c = '0;
        case (i_sel)
            2'b01:   step_c = {1'b0, i_data1} + {1'b0, i_data2};
            2'b10:   step_c = {1'b0, i_data1};
            default: step_c = '0;
        endcase
    end

    assign step_ext_c = NB_ACC'(step_c);
    assign diff_c     = o_data - step_ext_c;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            o_data       <= '0;
            o_underflow  <= 1'b0;
            o_done       <= 1'b0;
            o_busy       <= 1'b0;
            o_cycles     <= '0;
            o_load_ready <= 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_load_valid) begin
                        o_data      <= i_load_value;
                        o_cycles    <= '0;
                        o_underflow <= 1'b0;
                        // A zero load is already finished; it never enters RUN
                        if (i_load_value == '0) begin
                            state        <= ST_DONE;
                            o_done       <= 1'b1;
                            o_busy       <= 1'b0;
                            o_load_ready <= 1'b1;
                        end else begin
                            state        <= ST_RUN;
                            o_done       <= 1'b0;
                            o_busy       <= 1'b1;
                            o_load_ready <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_enable) begin
                        if (o_cycles != {NB_CNT{1'b1}}) begin
                            o_cycles <= o_cycles + NB_CNT'(1);
                        end
                        if (o_data > step_ext_c) begin
                            o_data <= diff_c;
                        end else begin
                            // Exact hit or wrap: both finish the run on this edge
                            o_data       <= diff_c;
                            o_underflow  <= (o_data != step_ext_c);
                            state        <= ST_DONE;
                            o_done       <= 1'b1;
                            o_busy       <= 1'b0;
                            o_load_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    o_done       <= 1'b0;
                    o_busy       <= 1'b0;
                    o_load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_ej_1.sv
// Directed vector bench for dec_ej_1: one table of per-cycle stimulus and expected
// post-edge outputs, plus hand sequences for the full 63-step run and mid-run reset.
module tb_dec_ej_1;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_load_valid = 1'b0;
    logic       o_load_ready;
    logic [5:0] i_load_value = '0;
    logic [2:0] i_data1 = '0;
    logic [2:0] i_data2 = '0;
    logic [1:0] i_sel = '0;
    logic       i_enable = 1'b0;
    logic [5:0] o_data;
    logic       o_underflow;
    logic       o_done;
    logic       o_busy;
    logic [7:0] o_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dec_ej_1 dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_load_valid (i_load_valid),
        .o_load_ready (o_load_ready),
        .i_load_value (i_load_value),
        .i_data1      (i_data1),
        .i_data2      (i_data2),
        .i_sel        (i_sel),
        .i_enable     (i_enable),
        .o_data       (o_data),
        .o_underflow  (o_underflow),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .o_cycles     (o_cycles)
    );

    typedef struct {
        logic       rst;
        logic       lv;
        logic [5:0] lval;
        logic [2:0] d1;
        logic [2:0] d2;
        logic [1:0] sel;
        logic       en;
        logic [5:0] e_data;
        logic       e_uf;
        logic       e_done;
        logic       e_busy;
        logic [7:0] e_cyc;
        logic       e_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic lv, input logic [5:0] lval,
                       input logic [2:0] d1, input logic [2:0] d2, input logic [1:0] sel,
                       input logic en, input logic [5:0] e_data, input logic e_uf,
                       input logic e_done, input logic e_busy, input logic [7:0] e_cyc,
                       input logic e_ready);
        vec_t v;
        v.rst = rst; v.lv = lv; v.lval = lval; v.d1 = d1; v.d2 = d2; v.sel = sel;
        v.en = en; v.e_data = e_data; v.e_uf = e_uf; v.e_done = e_done;
        v.e_busy = e_busy; v.e_cyc = e_cyc; v.e_ready = e_ready;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d want=%0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [5:0] e_data,
                           input logic e_uf, input logic e_done, input logic e_busy,
                           input logic [7:0] e_cyc, input logic e_ready);
        chk({tag, ".data"},  idx, 32'(o_data),       32'(e_data));
        chk({tag, ".uf"},    idx, 32'(o_underflow),  32'(e_uf));
        chk({tag, ".done"},  idx, 32'(o_done),       32'(e_done));
        chk({tag, ".busy"},  idx, 32'(o_busy),       32'(e_busy));
        chk({tag, ".cyc"},   idx, 32'(o_cycles),     32'(e_cyc));
        chk({tag, ".ready"}, idx, 32'(o_load_ready), 32'(e_ready));
    endtask

    task automatic drive(input logic rst, input logic lv, input logic [5:0] lval,
                         input logic [2:0] d1, input logic [2:0] d2, input logic [1:0] sel,
                         input logic en);
        i_rst = rst; i_load_valid = lv; i_load_value = lval;
        i_data1 = d1; i_data2 = d2; i_sel = sel; i_enable = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst lv  lval d1 d2 sel   en  data uf dn by cyc rdy
        add(1, 0,  0, 0, 0, 2'b00, 0,  0, 0, 0, 0, 0, 1);   // reset
        add(0, 1, 12, 2, 1, 2'b01, 1, 12, 0, 0, 1, 0, 0);   // load 12
        add(0, 0,  0, 2, 1, 2'b01, 1,  9, 0, 0, 1, 1, 0);
        add(0, 0,  0, 2, 1, 2'b01, 1,  6, 0, 0, 1, 2, 0);
        add(0, 0,  0, 2, 1, 2'b01, 1,  3, 0, 0, 1, 3, 0);
        add(0, 0,  0, 2, 1, 2'b01, 1,  0, 0, 1, 0, 4, 1);   // exact zero
        add(0, 0,  0, 2, 1, 2'b01, 1,  0, 0, 1, 0, 4, 1);   // DONE holds
        add(0, 1,  5, 2, 1, 2'b01, 1,  5, 0, 0, 1, 0, 0);   // load 5
        add(0, 0,  0, 2, 1, 2'b01, 1,  2, 0, 0, 1, 1, 0);
        add(0, 0,  0, 2, 1, 2'b01, 1, 63, 1, 1, 0, 2, 1);   // wrap
        add(0, 0,  0, 2, 1, 2'b01, 1, 63, 1, 1, 0, 2, 1);   // sticky
        add(0, 1,  7, 0, 0, 2'b11, 1,  7, 0, 0, 1, 0, 0);   // load 7, uf cleared
        add(0, 0,  0, 5, 5, 2'b11, 1,  7, 0, 0, 1, 1, 0);   // sel 11 -> step 0
        add(0, 0,  0, 5, 5, 2'b11, 1,  7, 0, 0, 1, 2, 0);
        add(0, 0,  0, 5, 5, 2'b00, 1,  7, 0, 0, 1, 3, 0);   // sel 00 -> step 0
        add(0, 0,  0, 7, 0, 2'b10, 0,  7, 0, 0, 1, 3, 0);   // enable low freezes
        add(0, 0,  0, 7, 7, 2'b01, 0,  7, 0, 0, 1, 3, 0);
        add(0, 0,  0, 7, 0, 2'b10, 1,  0, 0, 1, 0, 4, 1);   // d1=7 finishes
        add(0, 1,  0, 3, 3, 2'b01, 1,  0, 0, 1, 0, 0, 1);   // load 0 -> DONE
        add(0, 1, 40, 1, 0, 2'b10, 0, 40, 0, 0, 1, 0, 0);   // load 40
        add(0, 1,  5, 1, 0, 2'b10, 1, 39, 0, 0, 1, 1, 0);   // load in RUN ignored
        add(0, 0,  0, 7, 7, 2'b01, 1, 25, 0, 0, 1, 2, 0);   // step 14
        add(1, 1, 20, 1, 0, 2'b10, 1,  0, 0, 0, 0, 0, 1);   // reset beats load
        add(0, 0,  0, 1, 0, 2'b10, 1,  0, 0, 0, 0, 0, 1);   // stays IDLE

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].lv, vecs[i].lval, vecs[i].d1, vecs[i].d2,
                  vecs[i].sel, vecs[i].en);
            chk_all("vec", i, vecs[i].e_data, vecs[i].e_uf, vecs[i].e_done,
                    vecs[i].e_busy, vecs[i].e_cyc, vecs[i].e_ready);
        end

        // Full 63-step run by one, with a stray load pulse mid-run
        drive(0, 1, 63, 1, 0, 2'b10, 1);
        chk_all("l63", 0, 63, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 63; k++) begin
            drive(0, (k == 20), 6'd9, 1, 0, 2'b10, 1);
            chk("run63.data", k, 32'(o_data), 32'(63 - k));
            chk("run63.cyc",  k, 32'(o_cycles), 32'(k));
        end
        chk_all("end63", 63, 0, 0, 1, 0, 63, 1);

        // Mid-run reset at 30
        drive(0, 1, 32, 2, 0, 2'b10, 1);
        chk_all("l32", 0, 32, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 2, 0, 2'b10, 1);
        chk_all("at30", 1, 30, 0, 0, 1, 1, 0);
        drive(1, 0, 0, 7, 7, 2'b01, 1);
        chk_all("rst30", 2, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 7, 7, 2'b01, 1);
        chk_all("idle", 3, 0, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
